// File: rtl/byte_unstriping.sv
// byte_unstriping: receive-side un-striper. Takes one 4-lane symbol group per
// valid cycle, locks onto the first group whose lane0 is the COM symbol, holds
// up to two groups and replays them as one byte per clock, lane0 first.
module byte_unstriping #(
    parameter int                 DATA_W  = 8,
    parameter logic [DATA_W-1:0]  COM_SYM = 8'hBC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enb,
    input  logic [DATA_W-1:0] rx_lane0,
    input  logic [DATA_W-1:0] rx_lane1,
    input  logic [DATA_W-1:0] rx_lane2,
    input  logic [DATA_W-1:0] rx_lane3,
    input  logic              lanes_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] rx_Data,
    output logic              rx_Valid,
    output logic              aligned,
    output logic              overflow
);

    typedef enum logic [0:0] {
        ST_ALIGN  = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                         state_q, state_d;
    logic [1:0][3:0][DATA_W-1:0]    buf_q, buf_d;
    logic [1:0]                     count_q, count_d;
    logic                           wr_ptr_q, wr_ptr_d;
    logic                           rd_ptr_q, rd_ptr_d;
    logic [1:0]                     idx_q, idx_d;
    logic                           in_ready_q, in_ready_d;
    logic [DATA_W-1:0]              data_q, data_d;
    logic                           valid_q, valid_d;
    logic                           aligned_q, aligned_d;
    logic                           ovf_q, ovf_d;

    logic                           accept_s;
    logic                           capture_s;
    logic                           pop_s;
    logic                           last_pop_s;
    logic                           drop_s;

    // While hunting for alignment only a COM-led group is taken; once locked, all are.
    assign accept_s   = (state_q == ST_LOCKED) || (rx_lane0 == COM_SYM);
    assign capture_s  = enb && lanes_valid && in_ready_q && accept_s;
    assign pop_s      = enb && (count_q != 2'd0);
    assign last_pop_s = pop_s && (idx_q == 2'd3);
    // A full buffer drops the group even if a slot frees on this same edge.
    assign drop_s     = enb && lanes_valid && !in_ready_q && (state_q == ST_LOCKED);

    // Next-state logic: buffer write, serialiser read, occupancy and alignment FSM.
    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        idx_d      = idx_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        aligned_d  = aligned_q;
        ovf_d      = ovf_q;

        if (capture_s) begin
            buf_d[wr_ptr_q] = {rx_lane3, rx_lane2, rx_lane1, rx_lane0};
            wr_ptr_d        = ~wr_ptr_q;
        end else begin
            wr_ptr_d        = wr_ptr_q;
        end

        if (pop_s) begin
            data_d  = buf_q[rd_ptr_q][idx_q];
            valid_d = 1'b1;
            idx_d   = idx_q + 2'd1;
        end else begin
            data_d  = data_q;
            valid_d = 1'b0;
        end

        if (last_pop_s) begin
            rd_ptr_d = ~rd_ptr_q;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        count_d    = count_q + {1'b0, capture_s} - {1'b0, last_pop_s};
        in_ready_d = (count_d != 2'd2);

        if (drop_s) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end

        case (state_q)
            ST_ALIGN: begin
                if (capture_s) begin
                    state_d   = ST_LOCKED;
                    aligned_d = 1'b1;
                end else begin
                    state_d   = ST_ALIGN;
                end
            end
            ST_LOCKED: begin
                state_d = ST_LOCKED;
            end
            default: begin
                state_d   = ST_ALIGN;
                aligned_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any buffered bytes and forces re-alignment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_ALIGN;
            buf_q      <= '0;
            count_q    <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            idx_q      <= 2'd0;
            in_ready_q <= 1'b1;
            data_q     <= '0;
            valid_q    <= 1'b0;
            aligned_q  <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            idx_q      <= idx_d;
            in_ready_q <= in_ready_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            aligned_q  <= aligned_d;
            ovf_q      <= ovf_d;
        end
    end

    assign in_ready = in_ready_q;
    assign rx_Data  = data_q;
    assign rx_Valid = valid_q;
    assign aligned  = aligned_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_byte_unstriping.sv
// Bench for byte_unstriping: a behavioural model predicts which groups are
// taken and pushes their bytes to a scoreboard queue; each output byte pops it.
module tb_byte_unstriping;

    logic       clk;
    logic       rst;
    logic       enb;
    logic [7:0] rx_lane0, rx_lane1, rx_lane2, rx_lane3;
    logic       lanes_valid;
    logic       in_ready;
    logic [7:0] rx_Data;
    logic       rx_Valid;
    logic       aligned;
    logic       overflow;

    int total;
    int bad;

    // model state
    logic [7:0] q[$];
    int         m_count;
    int         m_idx;
    logic       m_locked;
    logic       m_ovf;
    logic [7:0] m_data;

    byte_unstriping #(.DATA_W(8), .COM_SYM(8'hBC)) dut (
        .clk         (clk),
        .rst         (rst),
        .enb         (enb),
        .rx_lane0    (rx_lane0),
        .rx_lane1    (rx_lane1),
        .rx_lane2    (rx_lane2),
        .rx_lane3    (rx_lane3),
        .lanes_valid (lanes_valid),
        .in_ready    (in_ready),
        .rx_Data     (rx_Data),
        .rx_Valid    (rx_Valid),
        .aligned     (aligned),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        if (obs !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_count  = 0;
        m_idx    = 0;
        m_locked = 1'b0;
        m_ovf    = 1'b0;
        m_data   = 8'h00;
    endtask

    // Assert reset between edges, check outputs at once, release off-edge.
    task automatic reset_dut();
        rst = 1'b1;
        enb = 1'b0;
        lanes_valid = 1'b0;
        #1;
        chk("rst_valid",    32'(rx_Valid), 32'd0);
        chk("rst_data",     32'(rx_Data),  32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_aligned",  32'(aligned),  32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        model_clear();
    endtask

    // One clock: drive inputs, predict, clock, compare.
    task automatic step(input logic e, input logic v,
                        input logic [7:0] l0, input logic [7:0] l1,
                        input logic [7:0] l2, input logic [7:0] l3);
        logic exp_v;
        logic pop;
        enb = e; lanes_valid = v;
        rx_lane0 = l0; rx_lane1 = l1; rx_lane2 = l2; rx_lane3 = l3;
        exp_v = 1'b0;
        if (e) begin
            pop = (m_count != 0);
            if (pop) begin
                exp_v  = 1'b1;
                m_data = q.pop_front();
            end
            if (v && m_count == 2 && m_locked) m_ovf = 1'b1;
            if (v && m_count != 2 && (m_locked || l0 == 8'hBC)) begin
                q.push_back(l0); q.push_back(l1); q.push_back(l2); q.push_back(l3);
                m_count  = m_count + 1;
                m_locked = 1'b1;
            end
            if (pop) begin
                m_idx = m_idx + 1;
                if (m_idx == 4) begin
                    m_idx   = 0;
                    m_count = m_count - 1;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("valid",    32'(rx_Valid), 32'(exp_v));
        chk("data",     32'(rx_Data),  32'(m_data));
        chk("in_ready", 32'(in_ready), 32'(m_count != 2));
        chk("aligned",  32'(aligned),  32'(m_locked));
        chk("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic grp(input logic [7:0] l0, input logic [7:0] l1,
                       input logic [7:0] l2, input logic [7:0] l3);
        step(1'b1, 1'b1, l0, l1, l2, l3);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1; enb = 1'b0; lanes_valid = 1'b0;
        rx_lane0 = 8'h00; rx_lane1 = 8'h00; rx_lane2 = 8'h00; rx_lane3 = 8'h00;
        model_clear();
        #2;
        reset_dut();

        // alignment: non-COM group discarded, COM group streams out
        grp(8'h11, 8'h22, 8'h33, 8'h44);
        grp(8'hBC, 8'h01, 8'h02, 8'h03);
        idle(6);

        // back-to-back groups every 4 cycles: continuous rx_Valid, capture
        // coincides with last-byte pop at count==1
        for (int g = 0; g < 4; g++) begin
            grp(8'($urandom_range(255)), 8'($urandom_range(255)),
                8'($urandom_range(255)), 8'($urandom_range(255)));
            idle(3);
        end
        idle(6);

        // groups every cycle: two stored, third dropped, overflow sticky
        grp(8'hA0, 8'hA1, 8'hA2, 8'hA3);
        grp(8'hB0, 8'hB1, 8'hB2, 8'hB3);
        grp(8'hC0, 8'hC1, 8'hC2, 8'hC3);
        grp(8'hD0, 8'hD1, 8'hD2, 8'hD3);
        idle(10);

        // enable pause mid-serialisation
        grp(8'hBC, 8'hAA, 8'h55, 8'hFF);
        idle(1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h77, 8'h77, 8'h77, 8'h77);
        idle(6);

        // reset mid-stream, then re-alignment required
        grp(8'h10, 8'h20, 8'h30, 8'h40);
        idle(2);
        reset_dut();
        idle(1);
        grp(8'h5A, 8'h5B, 8'h5C, 8'h5D);
        grp(8'hBC, 8'hE1, 8'hE2, 8'hE3);
        grp(8'h99, 8'h98, 8'h97, 8'h96);
        idle(10);

        chk("sb_drained", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
